pu_result_drain: RTL and testbench

- Downstream stage of the matrix-vector PU.
- Captures the PU's packed MATRIX_ROW-lane accumulator result (OUT) on the PU's DONE pulse into a shadow register bank.
- Streams the lanes out one per beat over a valid/ready interface, with row index and last flag, toward a result buffer or writeback path.
- Lets the PU start its next job while the previous result drains.

---
 rtl/pu_pkg.sv | 22 ++
 rtl/pu_result_drain_if.sv | 14 +
 rtl/pu_sat_round.sv | 40 ++++
 rtl/pu_result_drain.sv | 117 +++++++++++
 tb/tb_pu_result_drain.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/pu_pkg.sv
// Shared matrix-vector PU constants, index-width helper and the result-drain state type.
package pu_pkg;

  localparam int WIDTH_OP1  = 8;
  localparam int WIDTH_OP2  = 8;
  localparam int WIDTH_OUT  = 32;
  localparam int MATRIX_ROW = 8;
  localparam int MATRIX_COL = 8;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/pu_result_drain_if.sv
// Lane-per-beat result stream: valid/ready with lane index and last-lane flag.
interface pu_result_drain_if #(
  parameter int WIDTH_OUT = pu_pkg::WIDTH_OUT,
  parameter int IDX_W     = pu_pkg::clog2(pu_pkg::MATRIX_ROW)
);
  logic                 M_VALID;
  logic                 M_READY;
  logic [WIDTH_OUT-1:0] M_DATA;
  logic [IDX_W-1:0]     M_IDX;
  logic                 M_LAST;

  modport master (output M_VALID, output M_DATA, output M_IDX, output M_LAST, input M_READY);
  modport slave  (input M_VALID, input M_DATA, input M_IDX, input M_LAST, output M_READY);
endinterface

// File: rtl/pu_sat_round.sv
// One lane: round-half-up arithmetic right shift, then saturate to signed WIDTH_RES and
// sign-extend back to WIDTH_OUT. Purely combinational.
module pu_sat_round #(
  parameter int WIDTH_OUT = 32,
  parameter int WIDTH_RES = 16,
  parameter int RES_SHIFT = 4
) (
  input  logic [WIDTH_OUT-1:0] lane_i,
  output logic [WIDTH_OUT-1:0] lane_o
);
  // One guard bit so the rounding add cannot wrap a near-max positive lane.
  localparam int WX = WIDTH_OUT + 1;
  localparam logic signed [WX-1:0] RES_MAX = {{(WX-WIDTH_RES+1){1'b0}}, {(WIDTH_RES-1){1'b1}}};
  localparam logic signed [WX-1:0] RES_MIN = ~RES_MAX;

  logic signed [WX-1:0] ext;
  logic signed [WX-1:0] shf;
  logic signed [WX-1:0] sat;

  assign ext = {lane_i[WIDTH_OUT-1], lane_i};

  if (RES_SHIFT > 0) begin : g_round
    localparam logic signed [WX-1:0] HALF = {{(WX-1){1'b0}}, 1'b1} << (RES_SHIFT - 1);
    assign shf = (ext + HALF) >>> RES_SHIFT;
  end else begin : g_noround
    assign shf = ext;
  end

  always_comb begin
    sat = shf;
    if (shf > RES_MAX) begin
      sat = RES_MAX;
    end else if (shf < RES_MIN) begin
      sat = RES_MIN;
    end
  end

  assign lane_o = WIDTH_OUT'(sat);

endmodule

// File: rtl/pu_result_drain.sv
// Captures the PU's packed lane result on DONE and streams it one lane per beat, 1-cycle latency.
// Build with PU_DRAIN_SAT_EN to round/shift/saturate each lane at capture time.
module pu_result_drain #(
  parameter int WIDTH_OUT  = pu_pkg::WIDTH_OUT,
  parameter int MATRIX_ROW = pu_pkg::MATRIX_ROW,
  parameter int WIDTH_RES  = 16,
  parameter int RES_SHIFT  = 4
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            DONE,
  input  logic [WIDTH_OUT*MATRIX_ROW-1:0] OUT,
  pu_result_drain_if.master               m,
  output logic                            BUSY,
  output logic                            OVERRUN
);
  import pu_pkg::*;

  localparam int IDX_W = clog2(MATRIX_ROW);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MATRIX_ROW - 1);
  localparam bit CFG_OK = (MATRIX_ROW >= 2) && (WIDTH_RES >= 2) &&
                          (WIDTH_RES <= WIDTH_OUT) && (RES_SHIFT >= 0);

  if (!CFG_OK) begin : g_cfg_err
    $error("pu_result_drain: unsupported parameter combination");
  end

  drain_state_e         state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 overrun_q, overrun_d;
  logic [WIDTH_OUT-1:0] shadow_q [MATRIX_ROW];
  logic [WIDTH_OUT-1:0] lane_in  [MATRIX_ROW];
  logic                 capture;
  logic                 hs;
  logic                 at_last;

  for (genvar k = 0; k < MATRIX_ROW; k++) begin : g_lane
`ifdef PU_DRAIN_SAT_EN
    pu_sat_round #(
      .WIDTH_OUT (WIDTH_OUT),
      .WIDTH_RES (WIDTH_RES),
      .RES_SHIFT (RES_SHIFT)
    ) u_sat (
      .lane_i (OUT[WIDTH_OUT*k +: WIDTH_OUT]),
      .lane_o (lane_in[k])
    );
`else
    assign lane_in[k] = OUT[WIDTH_OUT*k +: WIDTH_OUT];
`endif
  end

  assign hs      = (state_q == DRAIN) && m.M_READY;
  assign at_last = (idx_q == IDX_LAST);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (DONE) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (hs && at_last) begin
          idx_d = '0;
          // A DONE landing on the final handshake chains straight into the next result.
          if (DONE) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (hs) begin
            idx_d = idx_q + IDX_W'(1);
          end
          if (DONE) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < MATRIX_ROW; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      if (capture) begin
        for (int k = 0; k < MATRIX_ROW; k++) begin
          shadow_q[k] <= lane_in[k];
        end
      end
    end
  end

  assign m.M_VALID = (state_q == DRAIN);
  assign m.M_DATA  = (state_q == DRAIN) ? shadow_q[idx_q] : '0;
  assign m.M_IDX   = idx_q;
  assign m.M_LAST  = (state_q == DRAIN) && at_last;
  assign BUSY      = (state_q == DRAIN);
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_pu_result_drain.sv
// Scoreboarded bench for pu_result_drain: directed scenarios followed by random DONE/READY traffic.
module tb_pu_result_drain;
  localparam int W  = 32;
  localparam int R  = 8;
  localparam int LW = W * R;

  logic          CLK = 1'b0;
  logic          RST;
  logic          DONE;
  logic [LW-1:0] OUT;
  logic          BUSY;
  logic          OVERRUN;

  pu_result_drain_if #(.WIDTH_OUT(W), .IDX_W(3)) mif ();

  pu_result_drain #(
    .WIDTH_OUT  (W),
    .MATRIX_ROW (R),
    .WIDTH_RES  (16),
    .RES_SHIFT  (4)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .DONE    (DONE),
    .OUT     (OUT),
    .m       (mif),
    .BUSY    (BUSY),
    .OVERRUN (OVERRUN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] d;
    int           idx;
  } beat_t;

  beat_t exp_q[$];
  bit    exp_ovr;
  int    n_vec;
  int    n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected lane value derived from the arithmetic rule, not from the RTL structure.
  function automatic logic [W-1:0] ref_lane(input logic [W-1:0] x);
`ifdef PU_DRAIN_SAT_EN
    longint v;
    longint hi;
    longint lo;
    v  = longint'($signed(x));
    v  = (v + 8) >>> 4;
    hi = 32767;
    lo = -32768;
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return W'(v);
`else
    return x;
`endif
  endfunction

  function automatic logic [LW-1:0] rnd_vec();
    logic [LW-1:0] v;
    for (int k = 0; k < R; k++) v[W*k +: W] = $urandom;
    return v;
  endfunction

  task automatic push_result(input logic [LW-1:0] o);
    for (int k = 0; k < R; k++) exp_q.push_back('{ref_lane(o[W*k +: W]), k});
  endtask

  // Drive one cycle's inputs from posedge+1, let the edge happen, then update the model.
  task automatic step(input logic d, input logic [LW-1:0] o, input logic r);
    bit acc;
    DONE        = d;
    OUT         = o;
    mif.M_READY = r;
    acc = d && (exp_q.size() == 0 || (exp_q.size() == 1 && r));
    @(posedge CLK);
    #1;
    if (d && !acc) exp_ovr = 1'b1;
    if (acc) push_result(o);
  endtask

  task automatic run_until(input int remaining);
    for (int i = 0; i < 50 && exp_q.size() != remaining; i++) step(1'b0, rnd_vec(), 1'b1);
    chk("sync_to_beat", 64'(exp_q.size()), 64'(remaining));
  endtask

  task automatic drain_all();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step(1'b0, rnd_vec(), 1'b1);
    chk("drain_complete", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compare every presented beat against the queue head; pop on handshake.
  always @(negedge CLK) begin
    if (RST) begin
      chk("rst_valid", 64'(mif.M_VALID), 64'd0);
      chk("rst_busy", 64'(BUSY), 64'd0);
      chk("rst_overrun", 64'(OVERRUN), 64'd0);
      chk("rst_data", 64'(mif.M_DATA), 64'd0);
      chk("rst_idx", 64'(mif.M_IDX), 64'd0);
    end else begin
      chk("valid", 64'(mif.M_VALID), 64'(exp_q.size() > 0));
      chk("busy", 64'(BUSY), 64'(exp_q.size() > 0));
      chk("overrun", 64'(OVERRUN), 64'(exp_ovr));
      if (mif.M_VALID && exp_q.size() > 0) begin
        chk("data", 64'(mif.M_DATA), 64'(exp_q[0].d));
        chk("idx", 64'(mif.M_IDX), 64'(exp_q[0].idx));
        chk("last", 64'(mif.M_LAST), 64'(exp_q[0].idx == R - 1));
        if (mif.M_READY) void'(exp_q.pop_front());
      end else if (!mif.M_VALID) begin
        chk("idle_data", 64'(mif.M_DATA), 64'd0);
        chk("idle_last", 64'(mif.M_LAST), 64'd0);
      end
    end
  end

  logic [LW-1:0] v;
  logic [LW-1:0] beef;
  logic [R-1:0]  bp_pat;

  initial begin
    n_vec       = 0;
    n_err       = 0;
    exp_ovr     = 1'b0;
    RST         = 1'b1;
    DONE        = 1'b0;
    OUT         = '0;
    mif.M_READY = 1'b0;
    for (int k = 0; k < R; k++) beef[W*k +: W] = 32'hDEADBEEF;
    #3;
    chk("reset_valid", 64'(mif.M_VALID), 64'd0);
    chk("reset_idx", 64'(mif.M_IDX), 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    step(1'b0, '0, 1'b1);

    // Basic drain: lane k = 1000*k - 3000.
    for (int k = 0; k < R; k++) v[W*k +: W] = W'(1000 * k - 3000);
    step(1'b1, v, 1'b1);
    drain_all();
    step(1'b0, '0, 1'b1);

    // Backpressure with OUT overwritten after capture.
    v = rnd_vec();
    step(1'b1, v, 1'b1);
    bp_pat = 8'b1111_0100;
    step(1'b0, beef, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, beef, bp_pat[i]);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, beef, 1'b1);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Back-to-back: DONE coincident with the final handshake, new lanes = 7*k.
    step(1'b1, rnd_vec(), 1'b1);
    run_until(1);
    for (int k = 0; k < R; k++) v[W*k +: W] = W'(7 * k);
    step(1'b1, v, 1'b1);
    chk("b2b_no_bubble", 64'(mif.M_VALID), 64'd1);
    chk("b2b_idx0", 64'(mif.M_IDX), 64'd0);
    drain_all();

    // Overrun while draining at idx 3.
    step(1'b1, rnd_vec(), 1'b1);
    run_until(5);
    step(1'b1, beef, 1'b0);
    drain_all();
    step(1'b0, '0, 1'b0);

    // Saturation corner lanes (pass-through in the default build).
    v[W*0 +: W] = 32'h7FFFFFFF;
    v[W*1 +: W] = W'(-1000000);
    v[W*2 +: W] = 32'd40;
    v[W*3 +: W] = W'(-40);
    v[W*4 +: W] = 32'h7FFFFFF8;
    v[W*5 +: W] = 32'd0;
    v[W*6 +: W] = 32'd15;
    v[W*7 +: W] = W'(-8);
    step(1'b1, v, 1'b1);
    drain_all();

    // Asynchronous reset at idx 4, between edges.
    step(1'b1, rnd_vec(), 1'b1);
    run_until(4);
    #1;
    RST = 1'b1;
    #1;
    chk("arst_valid", 64'(mif.M_VALID), 64'd0);
    chk("arst_busy", 64'(BUSY), 64'd0);
    chk("arst_idx", 64'(mif.M_IDX), 64'd0);
    chk("arst_data", 64'(mif.M_DATA), 64'd0);
    chk("arst_overrun", 64'(OVERRUN), 64'd0);
    exp_q.delete();
    exp_ovr = 1'b0;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #2;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    step(1'b1, rnd_vec(), 1'b1);
    drain_all();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 7) == 0), rnd_vec(), ($urandom_range(0, 3) != 0));
    end
    drain_all();
    step(1'b0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
